// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate type for the VGA ball
// datapath. Top-level parameters default to these values so a single
// instance can be retargeted (e.g. a shrunken raster) without editing here.
package vga_timing_pkg;

  // Width of hcount/vcount; every raster total must fit below 2**COORD_W.
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal timing, in pixels.
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  // Vertical timing, in lines.
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Derived totals (800 x 525 for the default mode).
  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Inclusive sync windows: hsync [656,751], vsync [490,491].
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // True when val lies in the inclusive window [lo, hi].
  function automatic logic in_window(input coord_t val, input coord_t lo,
                                     input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/pix_clk_div.sv
// Pixel-enable prescaler: a free-running 0..CLK_DIV-1 counter whose
// registered terminal-count flag gives a glitch-free one-clock pulse every
// CLK_DIV system clocks. The first pulse follows the CLK_DIV-th edge after
// reset release. Also used by the colour mux pipeline.
module pix_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pixpulse
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("pix_clk_div: CLK_DIV must be >= 2");
  end

  logic [CW-1:0] count;

  // Wrap the prescaler and register the pulse seen on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      pixpulse <= 1'b0;
    end else begin
      pixpulse <= (count == LAST);
      count    <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_scan_timing.sv
// Raster timing source: pixel enable, h/v counters, registered syncs and
// video_on, a vertical-blank move strobe and a frame_start pulse.
// Optional feature macro VGA_FRAME_CNT_EN adds a 16-bit frame_count output.
//
// Everything but the prescaler updates on the edge that ends a pixpulse
// cycle, so counts, syncs, video_on and move always describe the same pixel.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SYNC_ACTIVE = 0,
  parameter int MOVE_FRAMES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  output logic               pixpulse,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               move,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,output logic [15:0]       frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= (1 << COORD_W)) begin : g_bad_h
    $error("vga_scan_timing: H_TOTAL must be < 1024");
  end
  if (V_TOTAL >= (1 << COORD_W)) begin : g_bad_v
    $error("vga_scan_timing: V_TOTAL must be < 1024");
  end
  if (MOVE_FRAMES < 1) begin : g_bad_mf
    $error("vga_scan_timing: MOVE_FRAMES must be >= 1");
  end

  // All compares run against 10-bit constants fixed at elaboration.
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON = (SYNC_ACTIVE != 0);

  // Frame divider sized for 0..MOVE_FRAMES-1; a single bit that never
  // leaves 0 when every frame moves.
  localparam int DIV_W = (MOVE_FRAMES > 2) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_FRAMES - 1);

  coord_t            h_next;
  coord_t            v_next;
  logic              boundary;
  logic [DIV_W-1:0]  frame_div;

  pix_clk_div #(.CLK_DIV(CLK_DIV)) u_pix_clk_div (
    .clk      (clk),
    .rst      (rst),
    .pixpulse (pixpulse)
  );

  // Next raster position; the only wrap paths are end-of-line and
  // end-of-frame.
  always_comb begin
    h_next = hcount + coord_t'(1);
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + coord_t'(1);
    end
  end

  // Entering the first blank line: the move/divider decision point.
  assign boundary = pixpulse && (h_next == '0) && (v_next == V_VIS_C);

  // Counters plus syncs/video_on decoded from the next position, so the
  // decoded outputs change on the same edge as the counts they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pixpulse) begin
        hcount      <= h_next;
        vcount      <= v_next;
        hsync       <= in_window(h_next, HS_START, HS_END) ? SYNC_ON : ~SYNC_ON;
        vsync       <= in_window(v_next, VS_START, VS_END) ? SYNC_ON : ~SYNC_ON;
        video_on    <= (h_next < H_VIS_C) && (v_next < V_VIS_C);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

  // Move strobe lasts exactly one pixel period (the next counter edge
  // clears it). A paused boundary neither strobes nor advances the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move      <= 1'b0;
      frame_div <= '0;
    end else if (pixpulse) begin
      move <= 1'b0;
      if (boundary && !pause) begin
        move      <= (frame_div == '0);
        frame_div <= (frame_div == DIV_LAST) ? '0 : frame_div + DIV_W'(1);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Debug frame counter, free-running with natural 16-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing. A shrunken raster (24x12 total, CLK_DIV=4,
// MOVE_FRAMES=3) runs whole frames quickly; a second, default-parameter
// instance covers the real 640x480 line timing for a couple of lines.
`timescale 1ns/1ps
module tb_vga_scan_timing;

  localparam int CD = 4;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
  localparam int MF = 3;
  localparam int HT = HV + HF + HS + HB;   // 24
  localparam int VT = VV + VF + VS + VB;   // 12
  localparam int PH = HT * VT * CD;        // clocks per frame: 1152

  typedef struct packed {
    logic       pixpulse;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       move;
    logic       frame_start;
  } obs_t;

  // One record per frame-long phase: pause drive mode and expected tallies.
  // pmode: 0 low, 1 high all frame, 2 high only after the boundary,
  //        3 high only before the boundary.
  typedef struct {
    int pmode;
    int mv_clk;
    int mv_pix;
    int fs;
    int hs;
    int vs;
    int von;
    int pp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic pixpulse, hsync, vsync, video_on, move, frame_start;
  logic [9:0] hcount, vcount;

  logic rst2 = 1'b1;
  logic pause2 = 1'b0;
  logic pixpulse2, hsync2, vsync2, video_on2, move2, frame_start2;
  logic [9:0] hcount2, vcount2;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count, frame_count2;
`endif

  int ncmp = 0;
  int nfail = 0;

  obs_t exp_q[$];
  int   k = 0;
  int   mdiv = 0;
  logic mv = 1'b0;

  always #5 clk = ~clk;

  vga_scan_timing #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(0), .MOVE_FRAMES(MF)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .pixpulse(pixpulse),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .move(move), .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  vga_scan_timing dut2 (
    .clk(clk), .rst(rst2), .pause(pause2), .pixpulse(pixpulse2),
    .hcount(hcount2), .vcount(vcount2), .hsync(hsync2), .vsync(vsync2),
    .video_on(video_on2), .move(move2), .frame_start(frame_start2)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(frame_count2)
`endif
  );

  function automatic obs_t cur();
    obs_t o;
    o.pixpulse = pixpulse; o.hcount = hcount; o.vcount = vcount;
    o.hsync = hsync; o.vsync = vsync; o.video_on = video_on;
    o.move = move; o.frame_start = frame_start;
    return o;
  endfunction

  function automatic obs_t cur2();
    obs_t o;
    o.pixpulse = pixpulse2; o.hcount = hcount2; o.vcount = vcount2;
    o.hsync = hsync2; o.vsync = vsync2; o.video_on = video_on2;
    o.move = move2; o.frame_start = frame_start2;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hsync = 1'b1; o.vsync = 1'b1; o.video_on = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input int got, input int want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model: positions follow from k, the count of edges since
  // reset release (pixel n = (k-1)/CD); pushed at every edge.
  initial begin : model
    obs_t e;
    int   n, h, v;
    bit   ce;
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0; mdiv = 0; mv = 1'b0;
        exp_q.delete();
      end else begin
        k++;
        n  = (k - 1) / CD;
        h  = n % HT;
        v  = (n / HT) % VT;
        ce = (k > CD) && ((k - 1) % CD == 0);
        if (ce) begin
          mv = 1'b0;
          if (h == 0 && v == VV && !pause) begin
            mv   = (mdiv == 0);
            mdiv = (mdiv + 1) % MF;
          end
        end
        e.pixpulse    = (k % CD == 0);
        e.hcount      = 10'(h);
        e.vcount      = 10'(v);
        e.hsync       = !(h >= HV + HF && h <= HV + HF + HS - 1);
        e.vsync       = !(v >= VV + VF && v <= VV + VF + VS - 1);
        e.video_on    = (h < HV) && (v < VV);
        e.move        = mv;
        e.frame_start = ce && (h == 0) && (v == 0);
        exp_q.push_back(e);
      end
    end
  end

  // Scoreboard: compare DUT outputs mid-cycle against the model's entry.
  initial begin : scoreboard
    obs_t e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_obs("scoreboard", cur(), e);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t tbl[8];
    int   c_mv, c_mp, c_fs, c_hs, c_vs, c_von, c_pp, c_early, w;
    int   vid_h, hs_h;

    tbl[0] = '{0, 4, 1, 0, 144, 192, 384, 288};
    tbl[1] = '{0, 0, 0, 1, 144, 192, 384, 288};
    tbl[2] = '{0, 0, 0, 1, 144, 192, 384, 288};
    tbl[3] = '{1, 0, 0, 1, 144, 192, 384, 288};
    tbl[4] = '{0, 4, 1, 1, 144, 192, 384, 288};
    tbl[5] = '{2, 0, 0, 1, 144, 192, 384, 288};
    tbl[6] = '{0, 0, 0, 1, 144, 192, 384, 288};
    tbl[7] = '{3, 4, 1, 1, 144, 192, 384, 288};

    repeat (3) @(negedge clk);
    check_obs("reset state", cur(), reset_obs());
    check_obs("reset state default", cur2(), reset_obs());
    rst = 1'b0;

    // Eight frames of table-driven pause patterns.
    for (int i = 0; i < 8; i++) begin
      c_mv = 0; c_mp = 0; c_fs = 0; c_hs = 0; c_vs = 0; c_von = 0; c_pp = 0;
      for (int off = 1; off <= PH; off++) begin
        case (tbl[i].pmode)
          1:       pause = 1'b1;
          2:       pause = (off > 600);
          3:       pause = (off < 500);
          default: pause = 1'b0;
        endcase
        @(posedge clk);
        @(negedge clk);
        if (move) c_mv++;
        if (move && pixpulse) c_mp++;
        if (frame_start) c_fs++;
        if (!hsync) c_hs++;
        if (!vsync) c_vs++;
        if (video_on) c_von++;
        if (pixpulse) c_pp++;
      end
      check($sformatf("frame%0d move clocks", i), c_mv, tbl[i].mv_clk);
      check($sformatf("frame%0d pixpulse in move", i), c_mp, tbl[i].mv_pix);
      check($sformatf("frame%0d frame_start", i), c_fs, tbl[i].fs);
      check($sformatf("frame%0d hsync clocks", i), c_hs, tbl[i].hs);
      check($sformatf("frame%0d vsync clocks", i), c_vs, tbl[i].vs);
      check($sformatf("frame%0d video_on clocks", i), c_von, tbl[i].von);
      check($sformatf("frame%0d pixpulse count", i), c_pp, tbl[i].pp);
    end
    pause = 1'b0;
`ifdef VGA_FRAME_CNT_EN
    check("frame_count", int'(frame_count), 7);
`endif

    // Reset while the move strobe is high: async clear, no residual strobe.
    w = 0;
    while (!move && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check("move seen before reset", int'(move), 1);
    #1 rst = 1'b1;
    #1;
    check_obs("async reset mid-strobe", cur(), reset_obs());
    @(negedge clk);
    @(negedge clk);
    check_obs("held in reset", cur(), reset_obs());
    rst = 1'b0;
    c_mv = 0; c_early = 0;
    for (int off = 1; off <= PH; off++) begin
      @(posedge clk);
      @(negedge clk);
      if (move) begin
        c_mv++;
        if (off < 577) c_early++;
      end
    end
    check("post-reset early move", c_early, 0);
    check("post-reset move clocks", c_mv, 4);

    // Default 640x480 timing on the second instance: two lines.
    @(negedge clk);
    rst2 = 1'b0;
    vid_h = -1; hs_h = -1; c_hs = 0; c_vs = 0;
    for (int off = 1; off <= 3300; off++) begin
      @(posedge clk);
      @(negedge clk);
      if (off == 3) check("default pixpulse before 4th edge", int'(pixpulse2), 0);
      if (off == 4) check("default pixpulse at 4th edge", int'(pixpulse2), 1);
      if (off == 5) check("default hcount after first pixel", int'(hcount2), 1);
      if (!video_on2 && vid_h < 0) vid_h = int'(hcount2);
      if (!hsync2 && hs_h < 0) hs_h = int'(hcount2);
      if (off <= 3200 && !hsync2) c_hs++;
      if (!vsync2) c_vs++;
      if (off == 3200) begin
        check("default last pixel hcount", int'(hcount2), 799);
        check("default last pixel vcount", int'(vcount2), 0);
      end
      if (off == 3201) begin
        check("default wrap hcount", int'(hcount2), 0);
        check("default wrap vcount", int'(vcount2), 1);
      end
    end
    check("default video_on drop hcount", vid_h, 640);
    check("default hsync start hcount", hs_h, 656);
    check("default hsync clocks per line", c_hs, 384);
    check("default vsync clocks", c_vs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
